// File: rtl/odo_div_ctrl.sv
// odo_div_ctrl: period counter, ratio handshake and start/stop FSM for the odd/even clock divider
module odo_div_ctrl #(
  parameter int CNT_W       = 4,
  parameter int DIV_DEFAULT = 9,
  parameter int DIV_MIN     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [CNT_W-1:0] div_active,
  output logic [CNT_W-1:0] cnt,
  output logic             tc,
  output logic             p_hi,
  output logic             odd,
  output logic             running
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [CNT_W-1:0] MIN = CNT_W'(DIV_MIN);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DIV_DEFAULT);
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d, pend_q, pend_d;
  logic             pend_v_q, pend_v_d, p_hi_q, p_hi_d, err_q, err_d;
  logic             idle, xfer, good;
  assign idle       = state_q == IDLE;
  assign tc         = !idle && cnt_q == div_q - CNT_W'(1);
  assign cfg_ready  = !pend_v_q;
  assign cfg_err    = err_q;
  assign div_active = div_q;
  assign cnt        = cnt_q;
  assign p_hi       = p_hi_q;
  assign odd        = div_q[0];
  assign running    = !idle;
  always_comb begin
    xfer     = cfg_valid && !pend_v_q;
    good     = xfer && cfg_div >= MIN;
    err_d    = xfer && cfg_div < MIN;
    state_d  = idle ? (en ? RUN : IDLE) : en ? RUN : (state_q == DRAIN && tc) ? IDLE : DRAIN;
    cnt_d    = (idle || tc) ? '0 : cnt_q + CNT_W'(1);
    div_d    = (idle && good) ? cfg_div : (tc && pend_v_q) ? pend_q : div_q;
    pend_v_d = (!idle && good) || (pend_v_q && !tc);
    pend_d   = (!idle && good) ? cfg_div : pend_q;
    // N>>1 equals (N-1)/2 for odd N and N/2 for even N
    p_hi_d   = state_d != IDLE && cnt_d < (div_d >> 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= DEF;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      p_hi_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      p_hi_q   <= p_hi_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_odo_div_ctrl.sv
// tb_odo_div_ctrl: random stimulus against a cycle-level behavioural model of the divider controller
module tb_odo_div_ctrl;
  logic       clk = 1'b0;
  logic       rst, en, cfg_valid, cfg_ready, cfg_err, tc, p_hi, odd, running;
  logic [3:0] cfg_div, div_active, cnt;
  int n_cmp = 0, n_bad = 0;
  int m_mode, m_cnt, m_n, m_err;
  int m_pend[$];

  odo_div_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .div_active(div_active), .cnt(cnt),
    .tc(tc), .p_hi(p_hi), .odd(odd), .running(running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // mode: 0 idle, 1 run, 2 drain
  function automatic int m_tc();
    return (m_mode != 0 && m_cnt == m_n - 1) ? 1 : 0;
  endfunction

  task automatic model_step();
    int t, take;
    if (rst) begin
      m_mode = 0; m_cnt = 0; m_n = 9; m_err = 0; m_pend.delete();
      return;
    end
    t = m_tc();
    take = (cfg_valid && m_pend.size() == 0) ? 1 : 0;
    m_err = (take && cfg_div < 2) ? 1 : 0;
    if (cfg_div < 2) take = 0;
    if (m_mode == 0) begin
      if (take) m_n = cfg_div;
      m_cnt = 0;
      m_mode = en ? 1 : 0;
    end else begin
      if (t) begin
        m_cnt = 0;
        if (m_pend.size() != 0) m_n = m_pend.pop_front();
      end else m_cnt++;
      if (take) m_pend.push_back(int'(cfg_div));
      m_mode = en ? 1 : (m_mode == 2 && t) ? 0 : 2;
    end
  endtask

  task automatic check_all();
    int run;
    run = (m_mode != 0) ? 1 : 0;
    chk("cnt", cnt, m_cnt);
    chk("div_active", div_active, m_n);
    chk("running", running, run);
    chk("tc", tc, m_tc());
    chk("p_hi", p_hi, (run && 2 * m_cnt + 1 < m_n) ? 1 : 0);
    chk("odd", odd, m_n % 2);
    chk("cfg_ready", cfg_ready, m_pend.size() == 0 ? 1 : 0);
    chk("cfg_err", cfg_err, m_err);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = 4'd0;
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 11) == 0) en = ~en;
      cfg_valid = ($urandom_range(0, 9) == 0);
      cfg_div = 4'($urandom_range(0, 15));
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
